mac_tx_header_insert: RTL and testbench
=======================================

Name: mac_tx_header_insert

Overview:
- Upstream neighbour of the MAC TX frame-encapsulation stage.
- Accepts a per-frame header descriptor (destination MAC, EtherType) and a byte-wide AXI-Stream payload.
- Emits a byte stream of destination MAC, source MAC (mac_address), EtherType and payload. This stream feeds the encapsulation stage's tdata/tvalid/tready/tuser/tlast input.
- Enforces the maximum payload length by truncating oversize frames and marking them errored.

Parameters:
- MAX_PAYLOAD_LENGTH, 1500: maximum payload bytes forwarded per frame; excess is dropped.
- CNT_WDTH, $clog2(MAX_PAYLOAD_LENGTH+1): payload counter width (derived; do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- mac_address  input  48  station source MAC; sampled at header handshake
- hdr_valid  input  1  header descriptor valid
- hdr_ready  output  1  header descriptor accepted
- hdr_dest_mac  input  48  destination MAC
- hdr_ethertype  input  16  EtherType/length field
- s_tdata  input  8  payload byte
- s_tvalid  input  1  payload valid
- s_tready  output  1  payload ready
- s_tuser  input  1  payload error flag
- s_tlast  input  1  last payload byte
- m_tdata  output  8  frame byte to encapsulation stage
- m_tvalid  output  1  frame byte valid
- m_tready  input  1  downstream ready
- m_tuser  output  1  frame error flag
- m_tlast  output  1  last frame byte
- oversize_err  output  1  one-cycle pulse when a frame is truncated
- frame_count  output  16  completed frames emitted; wraps 0xFFFF->0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, hdr_idx=0, pay_cnt=0, header registers=0.
  - hdr_ready=1 (IDLE), s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0.
  - oversize_err=0, frame_count=0.
- Handshakes follow AXI-Stream rules. A transfer occurs when valid && ready. m_tdata, m_tlast and m_tuser are stable while m_tvalid=1 and m_tready=0.
- States: IDLE, HEADER, PAYLOAD, DROP.
- IDLE:
  - hdr_ready=1, s_tready=0, m_tvalid=0.
  - On hdr_valid: capture hdr_dest_mac, mac_address and hdr_ethertype, then go to HEADER with hdr_idx=0.
  - Payload arriving before its header is held off (s_tready=0).
- HEADER:
  - hdr_ready=0, s_tready=0, m_tvalid=1, m_tlast=0, m_tuser=0.
  - Byte order, MSB byte first:
    - hdr_idx 0-5: dest[47:40]..dest[7:0]
    - hdr_idx 6-11: src[47:40]..src[7:0]
    - hdr_idx 12: type[15:8]
    - hdr_idx 13: type[7:0]
  - hdr_idx advances only on an m transfer. A transfer at hdr_idx=13 goes to PAYLOAD with pay_cnt=0.
  - Latency: first header byte is presented the cycle after the hdr handshake. With m_tready held at 1, the frame is exactly 14 cycles of header followed by the payload.
- PAYLOAD (combinational pass-through, zero added latency):
  - m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready, m_tuser=s_tuser.
  - m_tlast = s_tlast OR (pay_cnt==MAX_PAYLOAD_LENGTH-1).
  - On each transfer pay_cnt increments.
  - Transfer with s_tlast=1: frame_count+1, go to IDLE.
  - Transfer at pay_cnt==MAX_PAYLOAD_LENGTH-1 with s_tlast=0: m_tuser forced 1 on that byte, oversize_err pulses the following cycle, frame_count+1, go to DROP.
  - s_tlast on exactly byte MAX_PAYLOAD_LENGTH is a normal frame: no error, no DROP.
- DROP:
  - s_tready=1, m_tvalid=0. Input bytes are discarded.
  - Transfer with s_tlast=1 goes to IDLE.
- Short payloads (fewer than 46 bytes) are forwarded unchanged; padding belongs to the encapsulation stage.
- Zero-length payload is not supported: every frame carries at least one payload byte.
- Back-to-back frames: IDLE costs exactly one cycle between the last payload byte and the next header's first byte. hdr_ready is asserted only in IDLE.
- s_tuser error marking propagates per byte without alteration except for the truncation override.
- Reset mid-frame:
  - Returns to IDLE next cycle and m_tvalid drops immediately. The downstream frame is left truncated; the system-level reset also resets the encapsulation stage.
  - Remaining input bytes of the aborted frame are not dropped automatically; the source is reset together with this block.
- frame_count and pay_cnt arithmetic is unsigned modulo 2^width.

Test Plan:
- Basic frame:
  - Stimulus: mac_address=02:00:00:00:00:01, hdr_dest_mac=FF:FF:FF:FF:FF:FF, hdr_ethertype=0x0800, payload 0x00..0x3F (64 bytes), m_tready=1.
  - Required: m_tdata sequence FF x6, 02 00 00 00 00 01, 08 00, 00..3F; m_tlast only on 0x3F; frame_count=1.
- Backpressure:
  - Stimulus: same frame, m_tready toggled pseudo-randomly (~50%).
  - Required: identical 78-byte output sequence; m_tdata stable during every stall; no byte duplicated or lost.
- Payload before header:
  - Stimulus: s_tvalid=1 for 10 cycles before hdr_valid.
  - Required: s_tready=0 throughout IDLE and HEADER; payload starts only after byte 13.
- Oversize:
  - Stimulus: MAX_PAYLOAD_LENGTH=1500, 1510-byte payload with tlast on byte 1510.
  - Required: 1514 output bytes; m_tlast=1 and m_tuser=1 on byte 1514; oversize_err one pulse; the last 10 input bytes accepted and discarded; frame_count=1.
- Exact max:
  - Stimulus: 1500-byte payload with tlast on byte 1500.
  - Required: m_tuser=0, oversize_err=0, normal return to IDLE.
- Reset mid-frame and back-to-back:
  - Stimulus: reset asserted during payload byte 20, then two 1-byte-payload frames back-to-back.
  - Required: m_tvalid=0 the cycle after reset; both subsequent frames are 15 bytes each with one idle cycle between them; frame_count=2.

Source files
------------

// File: rtl/mac_tx_header_insert.sv
// Prepends destination MAC, source MAC and EtherType to a byte-wide payload stream,
// truncating payloads longer than MAX_PAYLOAD_LENGTH and flagging them as errored.
module mac_tx_header_insert #(
   parameter int unsigned MAX_PAYLOAD_LENGTH = 1500,
   parameter int unsigned CNT_WDTH           = $clog2(MAX_PAYLOAD_LENGTH + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] mac_address,
   input  logic        hdr_valid,
   output logic        hdr_ready,
   input  logic [47:0] hdr_dest_mac,
   input  logic [15:0] hdr_ethertype,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tuser,
   input  logic        s_tlast,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tuser,
   output logic        m_tlast,
   output logic        oversize_err,
   output logic [15:0] frame_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HEADER  = 2'd1;
   localparam logic [1:0] PAYLOAD = 2'd2;
   localparam logic [1:0] DROP    = 2'd3;

   localparam logic [CNT_WDTH-1:0] PAY_LAST = CNT_WDTH'(MAX_PAYLOAD_LENGTH - 1);

   logic [1:0]          state_q, state_d;
   logic [3:0]          hdr_idx_q, hdr_idx_d;
   logic [CNT_WDTH-1:0] pay_cnt_q, pay_cnt_d;
   logic [47:0]         dest_q, dest_d;
   logic [47:0]         src_q, src_d;
   logic [15:0]         type_q, type_d;
   logic                oversize_q, oversize_d;
   logic [15:0]         frame_count_q, frame_count_d;

   logic [13:0][7:0]    hdr_bytes;
   logic                at_max;

   // Element 13 is the first byte on the wire (dest[47:40]).
   assign hdr_bytes = {dest_q, src_q, type_q};
   assign at_max    = (pay_cnt_q == PAY_LAST);

   always_comb begin
      state_d       = state_q;
      hdr_idx_d     = hdr_idx_q;
      pay_cnt_d     = pay_cnt_q;
      dest_d        = dest_q;
      src_d         = src_q;
      type_d        = type_q;
      oversize_d    = 1'b0;
      frame_count_d = frame_count_q;
      hdr_ready     = 1'b0;
      s_tready      = 1'b0;
      m_tvalid      = 1'b0;
      m_tdata       = '0;
      m_tlast       = 1'b0;
      m_tuser       = 1'b0;

      case (state_q)
         IDLE: begin
            hdr_ready = 1'b1;
            if (hdr_valid) begin
               dest_d    = hdr_dest_mac;
               src_d     = mac_address;
               type_d    = hdr_ethertype;
               hdr_idx_d = '0;
               state_d   = HEADER;
            end
         end
         HEADER: begin
            m_tvalid = 1'b1;
            m_tdata  = hdr_bytes[4'd13 - hdr_idx_q];
            if (m_tready) begin
               if (hdr_idx_q == 4'd13) begin
                  pay_cnt_d = '0;
                  state_d   = PAYLOAD;
               end else begin
                  hdr_idx_d = hdr_idx_q + 4'd1;
               end
            end
         end
         PAYLOAD: begin
            m_tdata  = s_tdata;
            m_tvalid = s_tvalid;
            s_tready = m_tready;
            m_tlast  = s_tlast | at_max;
            // A genuine tlast on the final allowed byte is a normal frame, not a truncation.
            m_tuser  = s_tuser | (at_max & ~s_tlast);
            if (s_tvalid && m_tready) begin
               pay_cnt_d = pay_cnt_q + CNT_WDTH'(1);
               if (s_tlast) begin
                  frame_count_d = frame_count_q + 16'd1;
                  state_d       = IDLE;
               end else if (at_max) begin
                  oversize_d    = 1'b1;
                  frame_count_d = frame_count_q + 16'd1;
                  state_d       = DROP;
               end
            end
         end
         DROP: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         hdr_idx_q     <= '0;
         pay_cnt_q     <= '0;
         dest_q        <= '0;
         src_q         <= '0;
         type_q        <= '0;
         oversize_q    <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         hdr_idx_q     <= hdr_idx_d;
         pay_cnt_q     <= pay_cnt_d;
         dest_q        <= dest_d;
         src_q         <= src_d;
         type_q        <= type_d;
         oversize_q    <= oversize_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign oversize_err = oversize_q;
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_mac_tx_header_insert.sv
// Bench for mac_tx_header_insert: frames are described up front, a queue model gives
// the expected output bytes, and driver/monitor processes exercise the handshakes.
module tb_mac_tx_header_insert;

   localparam int unsigned MAXP = 1500;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [47:0] mac_address = '0;
   logic        hdr_valid = 1'b0;
   logic        hdr_ready;
   logic [47:0] hdr_dest_mac = '0;
   logic [15:0] hdr_ethertype = '0;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tuser = 1'b0;
   logic        s_tlast = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tuser;
   logic        m_tlast;
   logic        oversize_err;
   logic [15:0] frame_count;

   mac_tx_header_insert #(.MAX_PAYLOAD_LENGTH(MAXP)) dut (
      .clk(clk), .reset(reset), .mac_address(mac_address),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .hdr_dest_mac(hdr_dest_mac), .hdr_ethertype(hdr_ethertype),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tuser(m_tuser), .m_tlast(m_tlast),
      .oversize_err(oversize_err), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       trunc;
      logic       user;
      logic       last;
      logic [7:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  drv_data[$];
   logic        drv_user[$];
   int unsigned drv_len[$];
   logic [47:0] drv_src[$];
   logic [47:0] drv_dest[$];
   logic [15:0] drv_type[$];
   int          xfer_cyc[$];

   int          checks = 0;
   int          errors = 0;
   int unsigned model_frames = 0;
   int          cycle = 0;
   bit          abort = 1'b0;
   bit          drv_done = 1'b0;
   bit          pre_valid = 1'b0;
   bit          rand_valid = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   // Expected wire bytes: 14 header bytes, then at most MAXP payload bytes; an
   // oversize frame ends on byte MAXP with tlast and tuser set.
   task automatic prepare_frame(input logic [47:0] src, input logic [47:0] dest,
                                input logic [15:0] et, input int unsigned len, input bit rnd);
      logic [111:0] hdr;
      int unsigned  kept;
      exp_t         e;
      logic [7:0]   d;
      logic         u;
      hdr  = {dest, src, et};
      kept = (len > MAXP) ? MAXP : len;
      for (int i = 0; i < 14; i++) begin
         e = '0;
         e.data = hdr[111 - 8*i -: 8];
         exp_q.push_back(e);
      end
      for (int unsigned i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(i);
         u = rnd ? ($urandom_range(7) == 0) : 1'b0;
         drv_data.push_back(d);
         drv_user.push_back(u);
         if (i < kept) begin
            e.trunc = (len > MAXP) && (i == kept - 1);
            e.user  = u | e.trunc;
            e.last  = (i == kept - 1);
            e.data  = d;
            exp_q.push_back(e);
         end
      end
      drv_len.push_back(len);
      drv_src.push_back(src);
      drv_dest.push_back(dest);
      drv_type.push_back(et);
      model_frames++;
   endtask

   task automatic send_frames();
      int unsigned len;
      int unsigned i;
      int          b;
      bit          x;
      while (drv_len.size() > 0 && !abort) begin
         len           = drv_len.pop_front();
         mac_address   = drv_src.pop_front();
         hdr_dest_mac  = drv_dest.pop_front();
         hdr_ethertype = drv_type.pop_front();
         if (pre_valid) begin
            s_tvalid = 1'b1;
            s_tdata  = drv_data[0];
            s_tuser  = drv_user[0];
            s_tlast  = (len == 1);
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               checks++;
               if (s_tready !== 1'b0) begin
                  errors++;
                  $display("FAIL early_s_tready got %b exp 0", s_tready);
               end
               @(posedge clk); #1;
            end
         end
         hdr_valid = 1'b1;
         b = 0;
         x = 1'b0;
         while (!x && !abort) begin
            @(negedge clk);
            x = hdr_ready;
            @(posedge clk); #1;
            b++;
            if (!x && b > 1000) begin
               checks++; errors++;
               $display("FAIL hdr_handshake_timeout got %0d cycles exp <= 1000", b);
               abort = 1'b1;
            end
         end
         hdr_valid = 1'b0;
         i = 0;
         b = 0;
         while (i < len && !abort) begin
            if (!s_tvalid) s_tvalid = rand_valid ? ($urandom_range(3) != 0) : 1'b1;
            s_tdata = drv_data[0];
            s_tuser = drv_user[0];
            s_tlast = (i == len - 1);
            @(negedge clk);
            x = s_tvalid && s_tready;
            @(posedge clk); #1;
            if (x) begin
               drv_data.delete(0);
               drv_user.delete(0);
               i++;
               s_tvalid = 1'b0;
            end
            b++;
            if (b > 20000) begin
               checks++; errors++;
               $display("FAIL payload_timeout got %0d accepted exp %0d", i, len);
               abort = 1'b1;
            end
         end
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         s_tuser  = 1'b0;
      end
      if (abort) begin
         drv_len.delete(); drv_src.delete(); drv_dest.delete(); drv_type.delete();
         drv_data.delete(); drv_user.delete();
      end
   endtask

   task automatic run_monitor(input bit rand_ready);
      int         budget;
      int         tail;
      int         out_idx;
      bit         ovr_exp;
      bit         stall;
      logic [9:0] held;
      exp_t       e;
      budget = 0; tail = 0; out_idx = 0; ovr_exp = 1'b0; stall = 1'b0; held = '0;
      xfer_cyc.delete();
      m_tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      while (tail < 4) begin
         @(negedge clk);
         checks++;
         if (oversize_err !== ovr_exp) begin
            errors++;
            $display("FAIL oversize_err got %b exp %b", oversize_err, ovr_exp);
         end
         ovr_exp = 1'b0;
         if (stall) begin
            checks++;
            if (m_tvalid !== 1'b1 || {m_tuser, m_tlast, m_tdata} !== held) begin
               errors++;
               $display("FAIL stall_stable got v=%b %h exp v=1 %h", m_tvalid,
                        {m_tuser, m_tlast, m_tdata}, held);
            end
         end
         if (m_tvalid && out_idx < 14) begin
            checks++;
            if (s_tready !== 1'b0 || hdr_ready !== 1'b0) begin
               errors++;
               $display("FAIL header_readies got s=%b h=%b exp 0 0", s_tready, hdr_ready);
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte got %h exp none", m_tdata);
            end else begin
               e = exp_q.pop_front();
               if ({m_tuser, m_tlast, m_tdata} !== {e.user, e.last, e.data}) begin
                  errors++;
                  $display("FAIL out_byte got user=%b last=%b data=%h exp user=%b last=%b data=%h",
                           m_tuser, m_tlast, m_tdata, e.user, e.last, e.data);
               end
               ovr_exp = e.trunc;
               out_idx = e.last ? 0 : out_idx + 1;
               xfer_cyc.push_back(cycle);
            end
         end
         stall = m_tvalid && !m_tready;
         held  = {m_tuser, m_tlast, m_tdata};
         if (exp_q.size() == 0 && drv_done) tail++;
         budget++;
         if (budget > 20000) begin
            checks++; errors++;
            $display("FAIL monitor_timeout got %0d bytes left exp 0", exp_q.size());
            exp_q.delete();
            tail = 4;
         end
         @(posedge clk); #1;
         if (rand_ready) m_tready = 1'($urandom_range(1));
      end
      m_tready = 1'b1;
   endtask

   task automatic run(input bit rv, input bit rr);
      @(posedge clk); #1;
      rand_valid = rv;
      drv_done   = 1'b0;
      fork
         begin send_frames(); drv_done = 1'b1; end
         run_monitor(rr);
      join
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks += 8;
      if (hdr_ready !== 1'b1) begin errors++; $display("FAIL rst_hdr_ready got %b exp 1", hdr_ready); end
      if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b exp 0", s_tready); end
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b exp 0", m_tvalid); end
      if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got %b exp 0", m_tlast); end
      if (m_tuser !== 1'b0) begin errors++; $display("FAIL rst_m_tuser got %b exp 0", m_tuser); end
      if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_m_tdata got %h exp 00", m_tdata); end
      if (oversize_err !== 1'b0) begin errors++; $display("FAIL rst_oversize got %b exp 0", oversize_err); end
      if (frame_count !== 16'h0) begin errors++; $display("FAIL rst_frame_count got %0d exp 0", frame_count); end
      model_frames = 0;
   endtask

   task automatic test_basic();
      prepare_frame(48'h02_00_00_00_00_01, 48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, 1'b0);
      run(1'b0, 1'b0);
      checks += 3;
      if (xfer_cyc.size() != 78) begin
         errors++; $display("FAIL basic_len got %0d exp 78", xfer_cyc.size());
      end else if (xfer_cyc[77] - xfer_cyc[0] != 77) begin
         errors++; $display("FAIL basic_contiguous got %0d exp 77", xfer_cyc[77] - xfer_cyc[0]);
      end
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL basic_frame_count got %0d exp %0d", frame_count, model_frames);
      end
      if (hdr_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got %b exp 1", hdr_ready); end
   endtask

   task automatic test_backpressure();
      prepare_frame(48'h02_00_00_00_00_01, 48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, 1'b0);
      run(1'b0, 1'b1);
      checks += 2;
      if (xfer_cyc.size() != 78) begin
         errors++; $display("FAIL bp_len got %0d exp 78", xfer_cyc.size());
      end
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL bp_frame_count got %0d exp %0d", frame_count, model_frames);
      end
   endtask

   task automatic test_hdr_first();
      pre_valid = 1'b1;
      prepare_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 20, 1'b1);
      run(1'b0, 1'b0);
      pre_valid = 1'b0;
      checks += 2;
      if (xfer_cyc.size() != 34 || xfer_cyc[14] - xfer_cyc[13] != 1) begin
         errors++; $display("FAIL hdr_first_payload_start got %0d bytes exp 34 contiguous", xfer_cyc.size());
      end
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL hdr_first_frame_count got %0d exp %0d", frame_count, model_frames);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         prepare_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
                       $urandom_range(80, 1), 1'b1);
      end
      run(1'b1, 1'b1);
      checks++;
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL random_frame_count got %0d exp %0d", frame_count, model_frames);
      end
   endtask

   task automatic test_oversize();
      prepare_frame(48'h02_00_00_00_00_01, 48'h11_22_33_44_55_66, 16'h88B5, MAXP + 10, 1'b0);
      run(1'b0, 1'b0);
      checks += 3;
      if (xfer_cyc.size() != 14 + MAXP) begin
         errors++; $display("FAIL oversize_len got %0d exp %0d", xfer_cyc.size(), 14 + MAXP);
      end
      if (drv_data.size() != 0) begin
         errors++; $display("FAIL oversize_drop got %0d unaccepted exp 0", drv_data.size());
      end
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL oversize_frame_count got %0d exp %0d", frame_count, model_frames);
      end
   endtask

   task automatic test_exact_max();
      prepare_frame(48'h02_00_00_00_00_01, 48'h11_22_33_44_55_66, 16'h0800, MAXP, 1'b0);
      run(1'b0, 1'b0);
      checks += 3;
      if (xfer_cyc.size() != 14 + MAXP) begin
         errors++; $display("FAIL exact_len got %0d exp %0d", xfer_cyc.size(), 14 + MAXP);
      end
      if (hdr_ready !== 1'b1) begin errors++; $display("FAIL exact_idle got %b exp 1", hdr_ready); end
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL exact_frame_count got %0d exp %0d", frame_count, model_frames);
      end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      int b;
      prepare_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 40, 1'b1);
      @(posedge clk); #1;
      rand_valid = 1'b0;
      m_tready   = 1'b1;
      fork
         send_frames();
         begin
            n = 0; b = 0;
            while (n < 33 && b < 1000) begin
               @(negedge clk);
               if (m_tvalid && m_tready) n++;
               b++;
               @(posedge clk); #1;
            end
            checks++;
            if (n != 33) begin errors++; $display("FAIL mid_reach_byte20 got %0d exp 33", n); end
            reset = 1'b1;
            abort = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            checks += 3;
            if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_m_tvalid got %b exp 0", m_tvalid); end
            if (hdr_ready !== 1'b1) begin errors++; $display("FAIL mid_hdr_ready got %b exp 1", hdr_ready); end
            if (frame_count !== 16'h0) begin errors++; $display("FAIL mid_frame_count got %0d exp 0", frame_count); end
         end
      join
      exp_q.delete();
      model_frames = 0;
      abort = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [47:0] src;
      src = {$urandom, $urandom};
      prepare_frame(src, {$urandom, $urandom}, 16'($urandom), 1, 1'b1);
      prepare_frame(src, {$urandom, $urandom}, 16'($urandom), 1, 1'b1);
      run(1'b0, 1'b0);
      checks++;
      if (xfer_cyc.size() != 30) begin
         errors++; $display("FAIL b2b_len got %0d exp 30", xfer_cyc.size());
      end else begin
         for (int i = 1; i < 30; i++) begin
            checks++;
            if (xfer_cyc[i] - xfer_cyc[i-1] != ((i == 15) ? 2 : 1)) begin
               errors++;
               $display("FAIL b2b_gap[%0d] got %0d exp %0d", i, xfer_cyc[i] - xfer_cyc[i-1],
                        (i == 15) ? 2 : 1);
            end
         end
      end
      checks++;
      if (frame_count !== 16'(model_frames)) begin
         errors++; $display("FAIL b2b_frame_count got %0d exp %0d", frame_count, model_frames);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_hdr_first();
      test_random();
      test_oversize();
      test_exact_max();
      test_reset_mid_frame();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
